// File: rtl/fpu_issue_scheduler_pkg.sv
// Shared definitions for the Cop1 FP ALU issue scheduler:
//   - FP ALU control codes (OP*) produced by FPALUControl
//   - COP1 funct codes (FUN*) that map onto those control codes
//   - scheduler state encoding
//   - busy-time constants per operation class (0 = unsupported funct)
package fpu_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } fpu_state_e;

  localparam logic [3:0] OPADDS  = 4'd0;
  localparam logic [3:0] OPSUBS  = 4'd1;
  localparam logic [3:0] OPMULS  = 4'd2;
  localparam logic [3:0] OPDIVS  = 4'd3;
  localparam logic [3:0] OPSQRTS = 4'd4;
  localparam logic [3:0] OPABSS  = 4'd5;
  localparam logic [3:0] OPMOVS  = 4'd6;
  localparam logic [3:0] OPNEGS  = 4'd7;
  localparam logic [3:0] OPCEQS  = 4'd8;
  localparam logic [3:0] OPCLTS  = 4'd9;
  localparam logic [3:0] OPCLES  = 4'd10;
  localparam logic [3:0] OPNOP   = 4'd15;

  localparam logic [5:0] FUNADD  = 6'h00;
  localparam logic [5:0] FUNSUB  = 6'h01;
  localparam logic [5:0] FUNMUL  = 6'h02;
  localparam logic [5:0] FUNDIV  = 6'h03;
  localparam logic [5:0] FUNSQRT = 6'h04;
  localparam logic [5:0] FUNABS  = 6'h05;
  localparam logic [5:0] FUNMOV  = 6'h06;
  localparam logic [5:0] FUNNEG  = 6'h07;
  localparam logic [5:0] FUNCEQ  = 6'h32;
  localparam logic [5:0] FUNCLT  = 6'h3C;
  localparam logic [5:0] FUNCLE  = 6'h3E;

  localparam logic [4:0] BUSY_NONE = 5'd0;
  localparam logic [4:0] BUSY_MISC = 5'd1;
  localparam logic [4:0] BUSY_CMP  = 5'd2;
  localparam logic [4:0] BUSY_MULS = 5'd4;
  localparam logic [4:0] BUSY_ADDS = 5'd6;
  localparam logic [4:0] BUSY_DIVS = 5'd10;
  localparam logic [4:0] BUSY_SQRT = 5'd15;

endpackage

// File: rtl/fpu_busy_counter.sv
// Loadable down-counter that times the FP ALU busy period.
//   iCLK/iRST : clock, asynchronous active-low reset
//   iLoad     : load iLoadVal this cycle
//   iEn       : decrement (saturates at zero, never wraps)
//   iClr      : clear to zero, highest priority
//   oZero     : counter currently holds zero
module fpu_busy_counter
  import fpu_issue_scheduler_pkg::*;
#(
  parameter int BUSY_W = 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLoad,
  input  logic [BUSY_W-1:0] iLoadVal,
  input  logic              iEn,
  input  logic              iClr,
  output logic              oZero
);

  logic [BUSY_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (iClr)                      count_d = '0;
    else if (iLoad)                count_d = iLoadVal;
    else if (iEn && count_q != '0) count_d = count_q - 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign oZero = (count_q == '0);

endmodule

// File: rtl/fpu_issue_scheduler.sv
// Issue scheduler for the single shared Cop1 FP ALU.
// Accepts one op at a time from decode, launches it (oStart), keeps the unit
// busy for iBusyTime cycles (oFPBusy), then raises a one-cycle writeback to
// either the FPR file (oWbEn/oWbReg) or the condition flag (oCondWbEn).
// oStall covers the structural hazard (unit in EXEC) and a RAW hazard against
// the destination being written back in the WB cycle. A zero busy time marks
// an unsupported funct: the op is consumed and oIllegal pulses instead.
// iFlush cancels the in-flight op; iRST (active-low, async) clears everything.
module fpu_issue_scheduler
  import fpu_issue_scheduler_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int BUSY_W = 5,
  parameter int REG_W  = 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iIssue,
  input  logic [OP_W-1:0]   iOp,
  input  logic [BUSY_W-1:0] iBusyTime,
  input  logic [REG_W-1:0]  iFd,
  input  logic [REG_W-1:0]  iFs,
  input  logic [REG_W-1:0]  iFt,
  input  logic              iUsesFt,
  input  logic              iIsCompare,
  input  logic              iFlush,
  output logic              oStall,
  output logic              oStart,
  output logic [OP_W-1:0]   oOp,
  output logic              oFPBusy,
  output logic              oWbEn,
  output logic [REG_W-1:0]  oWbReg,
  output logic              oCondWbEn,
  output logic              oIllegal
);

  fpu_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [REG_W-1:0]  dest_q;
  logic              cmp_q;
  logic              start_q, busy_q, wb_q, cond_q, illegal_q;
  logic [REG_W-1:0]  wbreg_q;

  logic in_exec, in_wb, hazard, accept, launch, bad_op, cnt_zero;

  assign in_exec = (state_q == ST_EXEC);
  assign in_wb   = (state_q == ST_WB);

  // Compares write only the flag, so they never create an FPR RAW hazard.
  assign hazard = ~cmp_q & ((iFs == dest_q) | (iUsesFt & (iFt == dest_q)));
  assign oStall = iIssue & (in_exec | (in_wb & hazard));

  assign accept = iIssue & ~oStall & ~iFlush;
  assign launch = accept & (iBusyTime != '0);
  assign bad_op = accept & (iBusyTime == '0);

  fpu_busy_counter #(.BUSY_W(BUSY_W)) u_cnt (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iLoad    (launch),
    .iLoadVal (iBusyTime - 1'b1),
    .iEn      (in_exec),
    .iClr     (iFlush),
    .oZero    (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    if (iFlush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (launch) state_d = ST_EXEC;
        ST_EXEC: if (cnt_zero) state_d = ST_WB;
        ST_WB:   state_d = launch ? ST_EXEC : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each is a clean flop output.
  // EXEC is the only way into WB, so cmp_q/dest_q still describe the finishing op.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      cmp_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      wb_q      <= 1'b0;
      cond_q    <= 1'b0;
      wbreg_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= launch;
      illegal_q <= bad_op;
      busy_q    <= (state_d == ST_EXEC);
      wb_q      <= (state_d == ST_WB) & ~cmp_q;
      cond_q    <= (state_d == ST_WB) & cmp_q;
      if (state_d == ST_WB) wbreg_q <= dest_q;
      if (launch) begin
        op_q   <= iOp;
        dest_q <= iFd;
        cmp_q  <= iIsCompare;
      end
    end
  end

  assign oStart    = start_q;
  assign oOp       = op_q;
  assign oFPBusy   = busy_q;
  assign oWbEn     = wb_q;
  assign oWbReg    = wbreg_q;
  assign oCondWbEn = cond_q;
  assign oIllegal  = illegal_q;

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
module tb_fpu_issue_scheduler;
  import fpu_issue_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iIssue, iUsesFt, iIsCompare, iFlush;
  logic [3:0] iOp;
  logic [4:0] iBusyTime, iFd, iFs, iFt;
  logic       oStall, oStart, oFPBusy, oWbEn, oCondWbEn, oIllegal;
  logic [3:0] oOp;
  logic [4:0] oWbReg;

  fpu_issue_scheduler #(.OP_W(4), .BUSY_W(5), .REG_W(5)) dut (
    .iCLK(clk), .iRST(rst_n), .iIssue(iIssue), .iOp(iOp), .iBusyTime(iBusyTime),
    .iFd(iFd), .iFs(iFs), .iFt(iFt), .iUsesFt(iUsesFt), .iIsCompare(iIsCompare),
    .iFlush(iFlush), .oStall(oStall), .oStart(oStart), .oOp(oOp), .oFPBusy(oFPBusy),
    .oWbEn(oWbEn), .oWbReg(oWbReg), .oCondWbEn(oCondWbEn), .oIllegal(oIllegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues: expected events tagged with the cycle they must appear in.
  typedef struct { int c; logic [3:0] op; } start_t;
  typedef struct { int c; logic [4:0] r; bit cmp; } wb_t;
  start_t sq[$];
  wb_t    wq[$];
  int     iq[$];

  // Reference model: the one op in flight, described by the cycles it occupies.
  bit         m_active = 0;
  int         m_wb = 0;
  logic [4:0] m_dest = 0;
  bit         m_cmp = 0;

  start_t ms;
  wb_t    mw;
  int     mi;

  // Monitor: pops and compares whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (oStart) begin
        if (sq.size() == 0) check("unexpected_start", oStart, 0);
        else begin
          ms = sq.pop_front();
          check("start_cycle", cyc, ms.c);
          check("start_op", oOp, ms.op);
        end
      end
      if (oWbEn || oCondWbEn) begin
        if (wq.size() == 0) check("unexpected_wb", oWbEn | oCondWbEn, 0);
        else begin
          mw = wq.pop_front();
          check("wb_cycle", cyc, mw.c);
          check("wb_fpr_en", oWbEn, !mw.cmp);
          check("wb_cond_en", oCondWbEn, mw.cmp);
          if (!mw.cmp) check("wb_reg", oWbReg, mw.r);
        end
      end
      if (oIllegal) begin
        if (iq.size() == 0) check("unexpected_illegal", oIllegal, 0);
        else begin
          mi = iq.pop_front();
          check("illegal_cycle", cyc, mi);
        end
      end
    end
  end

  // One decode cycle: drive inputs, check busy/stall, advance the model.
  task automatic step(input bit iss, input logic [3:0] op, input logic [4:0] bt,
                      input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft,
                      input bit uft, input bit cmp, input bit fl, output bit acc);
    int c;
    bit in_exec, in_wb, haz, stl;
    @(negedge clk);
    #1;
    c = cyc;
    in_exec = m_active && (c < m_wb);
    in_wb   = m_active && (c == m_wb);
    check("fpbusy", oFPBusy, in_exec);
    iIssue = iss; iOp = op; iBusyTime = bt; iFd = fd; iFs = fs; iFt = ft;
    iUsesFt = uft; iIsCompare = cmp; iFlush = fl;
    haz = !m_cmp && ((fs == m_dest) || (uft && (ft == m_dest)));
    stl = iss && (in_exec || (in_wb && haz));
    #1;
    check("stall", oStall, stl);
    acc = iss && !stl && !fl;
    if (fl) begin
      if (m_active && (m_wb > c)) void'(wq.pop_back());
      m_active = 0;
    end
    if (in_wb) m_active = 0;
    if (acc) begin
      if (bt == 0) iq.push_back(c + 1);
      else begin
        m_active = 1;
        m_wb     = c + 1 + int'(bt);
        m_dest   = fd;
        m_cmp    = cmp;
        sq.push_back(start_t'{c + 1, op});
        wq.push_back(wb_t'{c + 1 + int'(bt), fd, cmp});
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, a);
  endtask

  // Keeps presenting the same op until the model says it was taken (bounded).
  task automatic issue_until_taken(input string name, input logic [3:0] op, input logic [4:0] bt,
                                   input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft,
                                   input bit uft, input bit cmp);
    bit a = 0;
    for (int k = 0; k < 40 && !a; k++) step(1, op, bt, fd, fs, ft, uft, cmp, 0, a);
    check(name, a, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, oStall, 0);
    check({tag, "_start"}, oStart, 0);
    check({tag, "_op"}, oOp, 0);
    check({tag, "_busy"}, oFPBusy, 0);
    check({tag, "_wben"}, oWbEn, 0);
    check({tag, "_wbreg"}, oWbReg, 0);
    check({tag, "_condwb"}, oCondWbEn, 0);
    check({tag, "_illegal"}, oIllegal, 0);
  endtask

  initial begin
    bit a;
    logic [4:0] bt;
    int r;
    rst_n = 0; iIssue = 0; iOp = 0; iBusyTime = 0; iFd = 0; iFs = 0; iFt = 0;
    iUsesFt = 0; iIsCompare = 0; iFlush = 0;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    #1 rst_n = 1;

    // ADD.S busy 6, fd=3: start +1, busy +1..+6, FPR writeback +7.
    step(1, OPADDS, BUSY_ADDS, 5'd3, 5'd1, 5'd2, 1, 0, 0, a);
    idle(9);

    // MUL.S busy 4, then an independent op stalls through EXEC and is taken in WB.
    step(1, OPMULS, BUSY_MULS, 5'd7, 5'd1, 5'd2, 1, 0, 0, a);
    idle(1);
    issue_until_taken("mul_followup_taken", OPADDS, 5'd3, 5'd9, 5'd1, 5'd2, 1, 0);
    idle(6);

    // RAW on fs against fd=5: stalls in WB, taken in IDLE the cycle after.
    step(1, OPSUBS, 5'd2, 5'd5, 5'd0, 5'd0, 0, 0, 0, a);
    issue_until_taken("raw_fs_taken", OPMOVS, BUSY_MISC, 5'd6, 5'd5, 5'd0, 0, 0);
    idle(4);
    // RAW on ft only.
    step(1, OPSUBS, 5'd3, 5'd5, 5'd0, 5'd0, 0, 0, 0, a);
    issue_until_taken("raw_ft_taken", OPADDS, BUSY_MISC, 5'd6, 5'd1, 5'd5, 1, 0);
    idle(4);
    // C.EQ writes only the flag: no RAW stall in its WB cycle.
    step(1, OPCEQS, BUSY_CMP, 5'd5, 5'd1, 5'd2, 1, 1, 0, a);
    issue_until_taken("cmp_followup_taken", OPMOVS, BUSY_MISC, 5'd6, 5'd5, 5'd0, 0, 0);
    idle(4);

    // Unsupported funct (busy 0): illegal pulse only.
    step(1, OPNOP, BUSY_NONE, 5'd4, 5'd1, 5'd2, 1, 0, 0, a);
    idle(4);

    // SQRT busy 15 flushed in its 5th busy cycle with a same-cycle issue.
    step(1, OPSQRTS, BUSY_SQRT, 5'd8, 5'd1, 5'd2, 1, 0, 0, a);
    idle(4);
    step(1, OPADDS, 5'd3, 5'd9, 5'd1, 5'd2, 0, 0, 1, a);
    idle(20);

    // Reset in the middle of a DIV.S.
    step(1, OPDIVS, BUSY_DIVS, 5'd4, 5'd1, 5'd2, 1, 0, 0, a);
    idle(2);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check_zero("midop_reset");
    sq.delete(); wq.delete(); iq.delete(); m_active = 0;
    @(negedge clk);
    #1 check_zero("held_reset");
    #1 rst_n = 1;
    step(1, OPADDS, BUSY_ADDS, 5'd3, 5'd1, 5'd2, 1, 0, 0, a);
    idle(9);

    // Randomised traffic with small register space to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      bt = (r < 8) ? 5'd0 : (r < 85) ? 5'($urandom_range(1, 6)) : 5'($urandom_range(7, 31));
      step($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), bt,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0, a);
    end
    idle(40);

    check("start_queue_drained", sq.size(), 0);
    check("wb_queue_drained", wq.size(), 0);
    check("illegal_queue_drained", iq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_scheduler.md
Name: fpu_issue_scheduler

Overview:
- Sequences the single shared FP ALU for the Cop1 pipeline.
- Accepts FP ops from decode, together with the control code and busy time produced by FPALUControl.
- Launches each op on the FP ALU, holds the unit busy for the op's busy time, then raises a one-cycle writeback to the FP register file or the FP condition flag.
- Generates the decode stall for structural hazards (unit busy) and RAW hazards against the in-flight destination.

Parameters:
- OP_W, 4, width of the FP ALU control code.
- BUSY_W, 5, width of the busy-time field and the countdown counter.
- REG_W, 5, FPR index width.

Ports:
- iCLK  in  1  system clock; all state updates on the rising edge.
- iRST  in  1  asynchronous active-low reset.
- iIssue  in  1  decode presents a valid FP op this cycle.
- iOp  in  OP_W  FP ALU control code from FPALUControl.
- iBusyTime  in  BUSY_W  cycles the FP ALU needs; 0 marks an unsupported funct.
- iFd  in  REG_W  destination FPR.
- iFs  in  REG_W  source FPR 1.
- iFt  in  REG_W  source FPR 2.
- iUsesFt  in  1  op reads iFt.
- iIsCompare  in  1  op writes the condition flag, not an FPR.
- iFlush  in  1  cancel any in-flight op (branch/exception flush).
- oStall  out  1  decode must hold the current op.
- oStart  out  1  one-cycle launch pulse to the FP ALU.
- oOp  out  OP_W  latched control code driven to the FP ALU while busy.
- oFPBusy  out  1  high while an op is in EXEC.
- oWbEn  out  1  one-cycle FPR write enable.
- oWbReg  out  REG_W  FPR index written.
- oCondWbEn  out  1  one-cycle condition-flag write enable.
- oIllegal  out  1  one-cycle pulse when an op with busy time 0 is accepted.

Behaviour:
- Reset (iRST=0, asynchronous):
  - State goes to IDLE; counter, latched op and latched dest clear to 0.
  - All outputs are 0, including oOp and oWbReg.
  - Reset mid-op discards the op; no writeback follows.
- States and transitions:
  - IDLE -> EXEC on accept with iBusyTime != 0.
  - EXEC counts down.
  - EXEC -> WB when counter==0 at the clock edge.
  - WB -> IDLE, or WB -> EXEC if a new op is accepted in WB.
- Accept condition: iIssue & ~oStall.
- oStall = iIssue & (state==EXEC | (state==WB & hazard)).
  - hazard = ~latched_compare & (iFs==wb_reg | (iUsesFt & iFt==wb_reg)).
  - In IDLE, oStall is 0.
- Accept cycle T:
  - op, dest and compare flag are latched.
  - Counter loads iBusyTime-1.
  - State becomes EXEC at T+1.
- oStart: 1 during the first EXEC cycle only (T+1). oOp holds the latched code for the whole EXEC and WB period.
- Latency: writeback is asserted in cycle T+1+iBusyTime.
  - Busy time 1 -> WB at T+2.
  - Busy time 0x0F -> WB at T+16.
- WB cycle:
  - oWbEn = ~latched_compare, with oWbReg = latched dest.
  - oCondWbEn = latched_compare.
  - Exactly one cycle.
- Busy time 0:
  - Op is accepted and oIllegal pulses at T+1.
  - State stays IDLE; no oStart and no writeback.
- Back-to-back: accepting in WB overlaps the old writeback with the new op's load. The new oStart comes at the next cycle.
- oFPBusy = (state==EXEC).
- iFlush (synchronous):
  - Takes priority over everything: state -> IDLE next cycle and the counter clears.
  - A WB already asserted this cycle still completes.
  - iIssue in the same cycle as iFlush is not accepted; oStall still follows the rule above.
- Counter arithmetic is unsigned BUSY_W bits, decrement only in EXEC, never wraps (exit happens at 0).

Decomposition:
- Shared package (Parametros.v):
  - OP* control codes and FUN* codes.
  - State encoding localparams ST_IDLE=2'd0, ST_EXEC=2'd1, ST_WB=2'd2.
  - Busy-time constants.
- One sub-module, fpu_busy_counter: loadable down-counter with load, enable, clear and zero flag, same iCLK/iRST.

Test Plan:
- ADD.S (OPADDS, busy 6, fd=3) issued at cycle 0 from IDLE -> oStart at 1, oFPBusy 1..6, oWbEn=1 with oWbReg=3 at cycle 7 only.
- MUL.S busy 4 in EXEC, then a second op issued at cycle 2 -> oStall=1 through the EXEC cycles. In WB it is accepted if sources do not equal fd; its oStart follows in the next cycle.
- In WB of fd=5, issue with fs=5 -> oStall=1 for that cycle, accepted the next cycle in IDLE. Repeat with iIsCompare op (C.EQ) -> oCondWbEn=1, oWbEn=0, no RAW stall.
- Busy time 0 (default funct) -> oIllegal pulse one cycle later, no oStart, no writeback, oStall=0.
- SQRT (busy 0x0F) with iFlush at cycle 5 -> oFPBusy drops at cycle 6, no oWbEn ever. Same-cycle iIssue is not accepted.
- iRST low at cycle 3 of a DIV.S -> all outputs 0 immediately. After release, the next ADD.S behaves as in the first scenario.
